// File: rtl/rr_bus_arbiter3.sv
// rr_bus_arbiter3: three-requester round-robin bus arbiter with hold-limit rotation and registered data bus.
// Optional owner lock input is enabled by defining RR_ARB_LOCK_EN.
module rr_bus_arbiter3 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [2:0]       grant,
    output logic [1:0]       control,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             busy
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       control_q, control_d, last_q, last_d, nxt;
    logic [3:0]       hold_q, hold_d;
    logic [WIDTH-1:0] bus_q, bus_d, owner_data;
    logic             valid_q, valid_d, own_req, locked;
    logic [2:0]       others;

    // First set bit of r searching from one past 'from', wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
        logic [1:0] a, b;
        a = (from == 2'd2) ? 2'd0 : from + 2'd1;
        b = (a == 2'd2) ? 2'd0 : a + 2'd1;
        return r[a] ? a : (r[b] ? b : from);
    endfunction

`ifdef RR_ARB_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif

    // grant_q is 000 in IDLE, so others equals req there and one pick serves both states.
    assign own_req    = |(req & grant_q);
    assign others     = req & ~grant_q;
    assign nxt        = rr_pick(others, last_q);
    assign owner_data = (control_q == 2'd0) ? in1 : (control_q == 2'd1) ? in2 : in3;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        control_d = control_q;
        last_d    = last_q;
        hold_d    = hold_q;
        bus_d     = bus_q;
        valid_d   = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d   = OWN;
                grant_d   = 3'b001 << nxt;
                control_d = nxt;
                last_d    = nxt;
                hold_d    = 4'd1;
            end
        end else begin
            valid_d = own_req;
            bus_d   = own_req ? owner_data : bus_q;
            if (!own_req || (hold_q == 4'(MAX_HOLD) && |others && !locked)) begin
                if (|others) begin
                    grant_d   = 3'b001 << nxt;
                    control_d = nxt;
                    last_d    = nxt;
                    hold_d    = 4'd1;
                end else begin
                    state_d   = IDLE;
                    grant_d   = 3'b000;
                    control_d = 2'd0;
                    hold_d    = 4'd0;
                end
            end else begin
                hold_d = (hold_q == 4'(MAX_HOLD)) ? hold_q : hold_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            control_q <= 2'd0;
            last_q    <= 2'd2;
            hold_q    <= 4'd0;
            bus_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            control_q <= control_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            bus_q     <= bus_d;
            valid_q   <= valid_d;
        end
    end

    assign grant     = grant_q;
    assign control   = control_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign busy      = |grant_q;
endmodule
